// File: rtl/memory_system_ctrl.sv
// ============================================================================
// memory_system_ctrl
//
// Microsequencer for memory_system. Runs a four-state fetch/decode
// (F0 MAR<=PC, F1 MDR<=mem, F2 IR<=MDR and PC<=PC+1, DEC). It then runs a
// per-opcode execute sequence (E0..E2) and returns to F0. HALT parks the
// machine in HALTED until reset.
//
// Ports
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   start                 leave IDLE and begin fetching (ignored otherwise)
//   instruction[4:0]      IR opcode from memory_system
//   C, N, P, Z            latched ALU flags from memory_system
//   ir_sclr, mar_sclr     synchronous clears of IR / MAR (asserted in IDLE)
//   enaf                  flag latch enable
//   selop[2:0]            ALU operation (op1 = ACC, op2 = busB)
//   shamt[1:0]            shift amount, always zero
//   bank_wr_en            register bank write of busC
//   busB_addr, busC_addr  bank read / write addresses
//   ir_en, mar_en, mdr_en register load enables
//   wr_rdn                1 = memory write, 0 = read
//   mdr_alu_n             busC source: 1 = MDR, 0 = ALU
//   busy, halted          status; illegal pulses in DEC on an undefined opcode
// ============================================================================
module memory_system_ctrl #(
    parameter logic [2:0] PC_ADDR   = 3'b000,
    parameter logic [2:0] DPTR_ADDR = 3'b001,
    parameter logic [2:0] A_ADDR    = 3'b011,
    parameter logic [2:0] TEMP_ADDR = 3'b100,
    parameter logic [2:0] ACC_ADDR  = 3'b111
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [4:0] instruction,
    input  logic       C,
    input  logic       N,
    input  logic       P,
    input  logic       Z,
    output logic       ir_sclr,
    output logic       mar_sclr,
    output logic       enaf,
    output logic [2:0] selop,
    output logic [1:0] shamt,
    output logic       bank_wr_en,
    output logic [2:0] busB_addr,
    output logic [2:0] busC_addr,
    output logic       ir_en,
    output logic       mar_en,
    output logic       mdr_en,
    output logic       wr_rdn,
    output logic       mdr_alu_n,
    output logic       busy,
    output logic       halted,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_IDLE, S_F0, S_F1, S_F2, S_DEC, S_E0, S_E1, S_E2, S_HALTED
    } state_t;

    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_LDA  = 5'b01000;
    localparam logic [4:0] OP_STA  = 5'b01001;
    localparam logic [4:0] OP_MOVA = 5'b01010;
    localparam logic [4:0] OP_INCD = 5'b01011;
    localparam logic [4:0] OP_JZ   = 5'b01100;
    localparam logic [4:0] OP_JC   = 5'b01101;
    localparam logic [4:0] OP_HALT = 5'b11111;

    localparam logic [2:0] ALU_PASS_B = 3'b000;
    localparam logic [2:0] ALU_INC_B  = 3'b111;

    state_t state_q, state_d;
    logic   take_q, take_d;   // jump condition captured in DEC

    logic is_alu, has_exec, is_illegal;

    // N and P are not consumed by any current opcode.
    logic unused_flags;
    assign unused_flags = N ^ P;

    assign is_alu     = (instruction[4:3] == 2'b00) && (instruction[2:0] != 3'b000);
    // Opcodes 00001..01101 all need at least one execute cycle.
    assign has_exec   = (instruction != OP_NOP) && (instruction <= OP_JC);
    assign is_illegal = (instruction > OP_JC) && (instruction != OP_HALT);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            take_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            take_q  <= take_d;
        end
    end

    // Next-state logic. The flag is sampled only in DEC, so a flag update
    // during E0 cannot change a jump already decided.
    always_comb begin
        // NOTE: defaults first so every path assigns every signal; a missing
        // branch would otherwise infer a latch.
        state_d = state_q;
        take_d  = take_q;
        unique case (state_q)
            S_IDLE:   if (start) state_d = S_F0;
            S_F0:     state_d = S_F1;
            S_F1:     state_d = S_F2;
            S_F2:     state_d = S_DEC;
            S_DEC: begin
                take_d = ((instruction == OP_JZ) && Z) || ((instruction == OP_JC) && C);
                if (instruction == OP_HALT) state_d = S_HALTED;
                else if (has_exec)          state_d = S_E0;
                else                        state_d = S_F0;   // NOP and illegal
            end
            S_E0:     state_d = ((instruction == OP_LDA) || (instruction == OP_STA)) ? S_E1 : S_F0;
            S_E1:     state_d = (instruction == OP_LDA) ? S_E2 : S_F0;
            S_E2:     state_d = S_F0;
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase
    end

    // Moore outputs (plus the held opcode in execute states).
    always_comb begin
        ir_sclr    = 1'b0;
        mar_sclr   = 1'b0;
        enaf       = 1'b0;
        selop      = ALU_PASS_B;
        shamt      = 2'b00;
        bank_wr_en = 1'b0;
        busB_addr  = 3'b000;
        busC_addr  = 3'b000;
        ir_en      = 1'b0;
        mar_en     = 1'b0;
        mdr_en     = 1'b0;
        wr_rdn     = 1'b0;
        mdr_alu_n  = 1'b0;
        busy       = (state_q != S_IDLE) && (state_q != S_HALTED);
        halted     = (state_q == S_HALTED);
        illegal    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                ir_sclr  = 1'b1;
                mar_sclr = 1'b1;
            end
            S_F0: begin
                busB_addr = PC_ADDR;
                mar_en    = 1'b1;
            end
            S_F1: mdr_en = 1'b1;
            S_F2: begin
                ir_en      = 1'b1;
                busB_addr  = PC_ADDR;
                selop      = ALU_INC_B;
                busC_addr  = PC_ADDR;
                bank_wr_en = 1'b1;
            end
            S_DEC: illegal = is_illegal;
            S_E0: begin
                if (is_alu) begin
                    busB_addr  = A_ADDR;
                    selop      = instruction[2:0];
                    busC_addr  = ACC_ADDR;
                    bank_wr_en = 1'b1;
                    enaf       = 1'b1;
                end else if ((instruction == OP_LDA) || (instruction == OP_STA)) begin
                    busB_addr = DPTR_ADDR;
                    mar_en    = 1'b1;
                end else if (instruction == OP_MOVA) begin
                    busB_addr  = ACC_ADDR;
                    busC_addr  = A_ADDR;
                    bank_wr_en = 1'b1;
                end else if (instruction == OP_INCD) begin
                    busB_addr  = DPTR_ADDR;
                    selop      = ALU_INC_B;
                    busC_addr  = DPTR_ADDR;
                    bank_wr_en = 1'b1;
                end else if (take_q) begin
                    busB_addr  = TEMP_ADDR;
                    busC_addr  = PC_ADDR;
                    bank_wr_en = 1'b1;
                end
            end
            S_E1: begin
                mdr_en = 1'b1;
                if (instruction == OP_STA) begin
                    // ACC passes through the ALU onto the memory write path.
                    busB_addr = ACC_ADDR;
                    wr_rdn    = 1'b1;
                end
            end
            S_E2: begin
                mdr_alu_n  = 1'b1;
                busC_addr  = ACC_ADDR;
                bank_wr_en = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_memory_system_ctrl.sv
// ============================================================================
// tb_memory_system_ctrl
//
// Scoreboard bench for memory_system_ctrl. Each instruction pushes the
// expected per-cycle control vectors. The vectors come from a state/opcode
// table model. They are popped and compared at every falling edge.
// ============================================================================
module tb_memory_system_ctrl;

    typedef struct packed {
        logic       ir_sclr;
        logic       mar_sclr;
        logic       enaf;
        logic [2:0] selop;
        logic [1:0] shamt;
        logic       bank_wr_en;
        logic [2:0] busB_addr;
        logic [2:0] busC_addr;
        logic       ir_en;
        logic       mar_en;
        logic       mdr_en;
        logic       wr_rdn;
        logic       mdr_alu_n;
        logic       busy;
        logic       halted;
        logic       illegal;
    } ctrl_t;

    typedef enum int {T_IDLE, T_F0, T_F1, T_F2, T_DEC, T_E0, T_E1, T_E2, T_HALTED} tb_state_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [4:0] instruction;
    logic       C, N, P, Z;
    logic       ir_sclr, mar_sclr, enaf, bank_wr_en, ir_en, mar_en, mdr_en;
    logic       wr_rdn, mdr_alu_n, busy, halted, illegal;
    logic [2:0] selop, busB_addr, busC_addr;
    logic [1:0] shamt;

    ctrl_t act;
    ctrl_t exp_q[$];
    int    n_checks = 0;
    int    n_errors = 0;

    assign act = {ir_sclr, mar_sclr, enaf, selop, shamt, bank_wr_en, busB_addr,
                  busC_addr, ir_en, mar_en, mdr_en, wr_rdn, mdr_alu_n, busy,
                  halted, illegal};

    memory_system_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .instruction(instruction),
        .C(C), .N(N), .P(P), .Z(Z),
        .ir_sclr(ir_sclr), .mar_sclr(mar_sclr), .enaf(enaf), .selop(selop),
        .shamt(shamt), .bank_wr_en(bank_wr_en), .busB_addr(busB_addr),
        .busC_addr(busC_addr), .ir_en(ir_en), .mar_en(mar_en), .mdr_en(mdr_en),
        .wr_rdn(wr_rdn), .mdr_alu_n(mdr_alu_n), .busy(busy), .halted(halted),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input ctrl_t got, input ctrl_t want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Expected control vector for one state, written from the opcode table.
    function automatic ctrl_t exp_out(input tb_state_t st, input logic [4:0] op, input logic take);
        ctrl_t v = '0;
        v.busy = !(st inside {T_IDLE, T_HALTED});
        case (st)
            T_IDLE:   begin v.ir_sclr = 1; v.mar_sclr = 1; end
            T_F0:     begin v.busB_addr = 3'b000; v.mar_en = 1; end
            T_F1:     v.mdr_en = 1;
            T_F2:     begin v.ir_en = 1; v.busB_addr = 3'b000; v.selop = 3'b111;
                            v.busC_addr = 3'b000; v.bank_wr_en = 1; end
            T_DEC:    v.illegal = (op inside {[5'b01110:5'b11110]});
            T_E0: begin
                if (op inside {[5'b00001:5'b00111]}) begin
                    v.busB_addr = 3'b011; v.selop = op[2:0]; v.busC_addr = 3'b111;
                    v.bank_wr_en = 1; v.enaf = 1;
                end else if (op == 5'b01000 || op == 5'b01001) begin
                    v.busB_addr = 3'b001; v.mar_en = 1;
                end else if (op == 5'b01010) begin
                    v.busB_addr = 3'b111; v.busC_addr = 3'b011; v.bank_wr_en = 1;
                end else if (op == 5'b01011) begin
                    v.busB_addr = 3'b001; v.selop = 3'b111; v.busC_addr = 3'b001;
                    v.bank_wr_en = 1;
                end else if (take) begin
                    v.busB_addr = 3'b100; v.busC_addr = 3'b000; v.bank_wr_en = 1;
                end
            end
            T_E1: begin
                v.mdr_en = 1;
                if (op == 5'b01001) begin v.busB_addr = 3'b111; v.wr_rdn = 1; end
            end
            T_E2:     begin v.mdr_alu_n = 1; v.busC_addr = 3'b111; v.bank_wr_en = 1; end
            T_HALTED: v.halted = 1;
            default:  ;
        endcase
        return v;
    endfunction

    task automatic compare_next(input string tag);
        ctrl_t want;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: got %h expected <scoreboard empty>", tag, act);
        end else begin
            want = exp_q.pop_front();
            check(tag, act, want);
        end
    endtask

    // Called just after a falling edge where the next rising edge enters F0.
    // limit > 0 truncates the sequence (for the mid-instruction reset test).
    task automatic run_instr(input logic [4:0] op, input logic z, input logic c, input int limit);
        tb_state_t seq[$];
        logic      take;
        take = ((op == 5'b01100) && z) || ((op == 5'b01101) && c);
        seq.push_back(T_F0); seq.push_back(T_F1); seq.push_back(T_F2); seq.push_back(T_DEC);
        if (op == 5'b11111)                          seq.push_back(T_HALTED);
        else if (op inside {[5'b00001:5'b01101]})    seq.push_back(T_E0);
        if (op == 5'b01000 || op == 5'b01001)        seq.push_back(T_E1);
        if (op == 5'b01000)                          seq.push_back(T_E2);
        while (limit > 0 && seq.size() > limit) seq.delete(seq.size() - 1);
        foreach (seq[i]) exp_q.push_back(exp_out(seq[i], op, take));
        foreach (seq[i]) begin
            @(negedge clk);
            compare_next($sformatf("op%05b_z%0d_c%0d_cyc%0d", op, z, c, i));
            if (i == 0) begin
                // IR is loaded at the end of F2; presenting it here models that.
                start       = 1'b0;
                instruction = op;
                Z           = z;
                C           = c;
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; instruction = 5'b00000;
        C = 1'b0; N = 1'b0; P = 1'b0; Z = 1'b0;

        repeat (2) @(negedge clk);
        exp_q.push_back(exp_out(T_IDLE, 5'b0, 1'b0));
        compare_next("reset_idle");
        rst = 1'b0;
        @(negedge clk);
        exp_q.push_back(exp_out(T_IDLE, 5'b0, 1'b0));
        compare_next("idle_no_start");

        // Reset asserted while LDA sits in E1.
        start = 1'b1;
        run_instr(5'b01000, 1'b0, 1'b0, 6);
        rst = 1'b1;
        #1;
        exp_q.push_back(exp_out(T_IDLE, 5'b0, 1'b0));
        compare_next("async_reset_mid_lda");
        @(negedge clk);
        exp_q.push_back(exp_out(T_IDLE, 5'b0, 1'b0));
        compare_next("reset_held_idle");
        rst = 1'b0;

        start = 1'b1;
        run_instr(5'b00100, 1'b0, 1'b0, 0);   // XOR
        run_instr(5'b00000, 1'b0, 1'b0, 0);   // NOP
        run_instr(5'b00001, 1'b0, 1'b0, 0);   // ADD
        run_instr(5'b00111, 1'b0, 1'b0, 0);   // INC
        run_instr(5'b01000, 1'b0, 1'b0, 0);   // LDA
        run_instr(5'b01001, 1'b0, 1'b0, 0);   // STA
        run_instr(5'b01010, 1'b0, 1'b0, 0);   // MOVA
        run_instr(5'b01011, 1'b0, 1'b0, 0);   // INCD
        run_instr(5'b01100, 1'b1, 1'b0, 0);   // JZ taken
        run_instr(5'b01100, 1'b0, 1'b1, 0);   // JZ not taken (C set)
        run_instr(5'b01101, 1'b0, 1'b1, 0);   // JC taken
        run_instr(5'b01101, 1'b1, 1'b0, 0);   // JC not taken (Z set)
        run_instr(5'b10101, 1'b0, 1'b0, 0);   // illegal
        run_instr(5'b01110, 1'b0, 1'b0, 0);   // illegal, lowest undefined
        run_instr(5'b11110, 1'b0, 1'b0, 0);   // illegal, highest undefined
        run_instr(5'b11111, 1'b0, 1'b0, 0);   // HALT

        start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(exp_out(T_HALTED, 5'b11111, 1'b0));
            @(negedge clk);
            compare_next($sformatf("halted_start_ignored_%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
